issue_scheduler: RTL and testbench

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/iq_pkg.sv | 16 +
 rtl/age_matrix_select.sv | 45 ++++
 rtl/issue_scheduler.sv | 128 ++++++++++++
 tb/tb_issue_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// Shared types for the issue scheduler: entry layout and tag width.
package iq_pkg;
    localparam int IQ_ROB_COUNT = 32;
    localparam int IQ_TW        = $clog2(IQ_ROB_COUNT);
    localparam int IQ_PAYLOAD_W = 32;

    typedef struct packed {
        logic                    valid;
        logic [IQ_PAYLOAD_W-1:0] payload;
        logic [IQ_TW-1:0]        dst;
        logic [IQ_TW-1:0]        src1;
        logic                    src1_rdy;
        logic [IQ_TW-1:0]        src2;
        logic                    src2_rdy;
    } iq_entry_t;
endpackage

// File: rtl/age_matrix_select.sv
// Oldest-first picker: owns the age matrix and grants the oldest eligible entry.
module age_matrix_select #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [N-1:0] alloc,
    input  logic [N-1:0] elig,
    output logic [N-1:0] grant,
    output logic         grant_valid
);
    // older[r][c] set means entry r was written before entry c
    logic [N-1:0][N-1:0] older;
    logic                blocked;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            older <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (alloc[k]) begin
                    for (int j = 0; j < N; j++) begin
                        older[k][j] <= 1'b0;
                        older[j][k] <= (j != k);
                    end
                end
            end
        end
    end

    always_comb begin
        grant   = '0;
        blocked = 1'b0;
        for (int i = 0; i < N; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < N; j++)
                if (j != i && elig[j] && older[j][i])
                    blocked = 1'b1;
            grant[i] = elig[i] && !blocked;
        end
    end

    assign grant_valid = |grant;
endmodule

// File: rtl/issue_scheduler.sv
// Out-of-order issue queue: dispatch, tag wakeup, oldest-ready select into one output slot.
module issue_scheduler
    import iq_pkg::*;
#(
    parameter int IQ_SIZE   = 8,
    parameter int ROB_COUNT = IQ_ROB_COUNT,
    parameter int PAYLOAD_W = IQ_PAYLOAD_W,
    localparam int TW = $clog2(ROB_COUNT),
    localparam int CW = $clog2(IQ_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 disp_valid_i,
    output logic                 disp_ready_o,
    input  logic [PAYLOAD_W-1:0] disp_payload_i,
    input  logic [TW-1:0]        disp_dst_i,
    input  logic [TW-1:0]        disp_src1_i,
    input  logic [TW-1:0]        disp_src2_i,
    input  logic                 disp_src1_rdy_i,
    input  logic                 disp_src2_rdy_i,
    input  logic                 wb_valid_i,
    input  logic [TW-1:0]        wb_tag_i,
    output logic                 iss_valid_o,
    input  logic                 iss_ready_i,
    output logic [PAYLOAD_W-1:0] iss_payload_o,
    output logic [TW-1:0]        iss_dst_o,
    input  logic                 flush_i,
    output logic [CW-1:0]        count_o
);
    iq_entry_t              ent [IQ_SIZE];
    iq_entry_t              new_ent;
    logic [IQ_SIZE-1:0]     alloc, elig, grant;
    logic                   grant_valid, found, accept, load;
    logic [PAYLOAD_W-1:0]   sel_payload;
    logic [TW-1:0]          sel_dst;

    assign disp_ready_o = (count_o < CW'(IQ_SIZE)) && !flush_i;
    assign accept       = disp_valid_i && disp_ready_o;
    assign load         = grant_valid && (!iss_valid_o || iss_ready_i);

    always_comb begin
        alloc = '0;
        found = 1'b0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            elig[i] = ent[i].valid && ent[i].src1_rdy && ent[i].src2_rdy;
            if (!ent[i].valid && !found) begin
                alloc[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // A source matching the in-flight broadcast is captured as already ready
    always_comb begin
        new_ent          = '0;
        new_ent.valid    = 1'b1;
        new_ent.payload  = disp_payload_i;
        new_ent.dst      = disp_dst_i;
        new_ent.src1     = disp_src1_i;
        new_ent.src2     = disp_src2_i;
        new_ent.src1_rdy = disp_src1_rdy_i || (wb_valid_i && wb_tag_i == disp_src1_i);
        new_ent.src2_rdy = disp_src2_rdy_i || (wb_valid_i && wb_tag_i == disp_src2_i);
    end

    always_comb begin
        sel_payload = '0;
        sel_dst     = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            if (grant[i]) begin
                sel_payload = ent[i].payload;
                sel_dst     = ent[i].dst;
            end
        end
    end

    age_matrix_select #(.N(IQ_SIZE)) u_sel (
        .clk         (clk),
        .rst         (rst),
        .clear       (flush_i),
        .alloc       (accept ? alloc : '0),
        .elig        (elig),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < IQ_SIZE; i++) begin
            if (rst || flush_i) begin
                ent[i].valid    <= 1'b0;
                ent[i].src1_rdy <= 1'b0;
                ent[i].src2_rdy <= 1'b0;
            end else if (accept && alloc[i]) begin
                ent[i] <= new_ent;
            end else begin
                if (load && grant[i])
                    ent[i].valid <= 1'b0;
                if (wb_valid_i && ent[i].valid && ent[i].src1 == wb_tag_i)
                    ent[i].src1_rdy <= 1'b1;
                if (wb_valid_i && ent[i].valid && ent[i].src2 == wb_tag_i)
                    ent[i].src2_rdy <= 1'b1;
            end
        end
    end

    // Payload/dst only change on a load, so they hold while the FU stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_o   <= 1'b0;
            iss_payload_o <= '0;
            iss_dst_o     <= '0;
        end else if (flush_i) begin
            iss_valid_o <= 1'b0;
        end else if (load) begin
            iss_valid_o   <= 1'b1;
            iss_payload_o <= sel_payload;
            iss_dst_o     <= sel_dst;
        end else if (iss_ready_i) begin
            iss_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i)
            count_o <= '0;
        else
            count_o <= count_o + CW'(accept) - CW'(load);
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler with an in-order-age queue model checked every cycle.
module tb_issue_scheduler;
    localparam int IQ = 8;
    localparam int TW = 5;
    localparam int PW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_valid_i, disp_ready_o;
    logic [PW-1:0] disp_payload_i;
    logic [TW-1:0] disp_dst_i, disp_src1_i, disp_src2_i;
    logic          disp_src1_rdy_i, disp_src2_rdy_i;
    logic          wb_valid_i;
    logic [TW-1:0] wb_tag_i;
    logic          iss_valid_o, iss_ready_i;
    logic [PW-1:0] iss_payload_o;
    logic [TW-1:0] iss_dst_o;
    logic          flush_i;
    logic [CW-1:0] count_o;

    issue_scheduler #(.IQ_SIZE(IQ), .ROB_COUNT(32), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst(rst),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_payload_i(disp_payload_i), .disp_dst_i(disp_dst_i),
        .disp_src1_i(disp_src1_i), .disp_src2_i(disp_src2_i),
        .disp_src1_rdy_i(disp_src1_rdy_i), .disp_src2_rdy_i(disp_src2_rdy_i),
        .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i),
        .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
        .iss_payload_o(iss_payload_o), .iss_dst_o(iss_dst_o),
        .flush_i(flush_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] pay;
        logic [TW-1:0] dst, s1, s2;
        bit            r1, r2;
    } m_ent_t;

    m_ent_t        mq[$];
    m_ent_t        m_new;
    bit            m_live = 0;
    bit            m_ov;
    logic [PW-1:0] m_pay;
    logic [TW-1:0] m_dst;
    bit            m_acc;
    int            m_pick;
    int            checks = 0;
    int            errors = 0;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Queue index order is age order; selection uses pre-edge readiness,
    // then broadcasts wake survivors, then the new dispatch joins as youngest.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ov   = 0;
            m_pay  = '0;
            m_dst  = '0;
            m_live = 1;
        end else if (flush_i) begin
            mq.delete();
            m_ov = 0;
        end else begin
            m_acc  = disp_valid_i && (mq.size() < IQ);
            m_pick = -1;
            if (!m_ov || iss_ready_i) begin
                foreach (mq[k])
                    if (m_pick < 0 && mq[k].r1 && mq[k].r2) m_pick = k;
                if (m_pick >= 0) begin
                    m_ov  = 1;
                    m_pay = mq[m_pick].pay;
                    m_dst = mq[m_pick].dst;
                    mq.delete(m_pick);
                end else begin
                    m_ov = 0;
                end
            end
            if (wb_valid_i)
                foreach (mq[k]) begin
                    if (mq[k].s1 == wb_tag_i) mq[k].r1 = 1;
                    if (mq[k].s2 == wb_tag_i) mq[k].r2 = 1;
                end
            if (m_acc) begin
                m_new.pay = disp_payload_i;
                m_new.dst = disp_dst_i;
                m_new.s1  = disp_src1_i;
                m_new.s2  = disp_src2_i;
                m_new.r1  = disp_src1_rdy_i || (wb_valid_i && wb_tag_i == disp_src1_i);
                m_new.r2  = disp_src2_rdy_i || (wb_valid_i && wb_tag_i == disp_src2_i);
                mq.push_back(m_new);
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            cmp("iss_valid", 32'(iss_valid_o), 32'(m_ov));
            cmp("count", 32'(count_o), 32'(mq.size()));
            cmp("disp_ready", 32'(disp_ready_o), 32'((mq.size() < IQ) && !flush_i));
            if (m_ov) begin
                cmp("iss_dst", 32'(iss_dst_o), 32'(m_dst));
                cmp("iss_payload", iss_payload_o, m_pay);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        disp_valid_i = 0;
        wb_valid_i   = 0;
        flush_i      = 0;
    endtask

    task automatic disp(input int dst, input int s1, input bit r1, input int s2, input bit r2);
        disp_valid_i    = 1;
        disp_payload_i  = 32'hC0DE_0000 | 32'(dst);
        disp_dst_i      = TW'(dst);
        disp_src1_i     = TW'(s1);
        disp_src1_rdy_i = r1;
        disp_src2_i     = TW'(s2);
        disp_src2_rdy_i = r2;
    endtask

    task automatic wb(input int tag);
        wb_valid_i = 1;
        wb_tag_i   = TW'(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; disp_valid_i = 0; disp_payload_i = '0; disp_dst_i = '0;
        disp_src1_i = '0; disp_src2_i = '0; disp_src1_rdy_i = 0; disp_src2_rdy_i = 0;
        wb_valid_i = 0; wb_tag_i = '0; iss_ready_i = 1; flush_i = 0;
        repeat (2) @(posedge clk);
        #2 rst = 0;
        cmp("rst_iss_valid", 32'(iss_valid_o), 0);
        cmp("rst_count", 32'(count_o), 0);
        cmp("rst_disp_ready", 32'(disp_ready_o), 1);
        cmp("rst_payload", iss_payload_o, 0);
        cmp("rst_dst", 32'(iss_dst_o), 0);

        // three ready instructions issue back to back, first two cycles after dispatch
        disp(5, 0, 1, 0, 1); tick(); cmp("b2b_n1_valid", 32'(iss_valid_o), 0);
        disp(6, 0, 1, 0, 1); tick(); cmp("b2b_dst5", 32'(iss_dst_o), 5);
        disp(7, 0, 1, 0, 1); tick(); cmp("b2b_dst6", 32'(iss_dst_o), 6);
        tick(); cmp("b2b_dst7", 32'(iss_dst_o), 7);
        tick(); cmp("b2b_drained", 32'(iss_valid_o), 0);

        // older waiting entry is overtaken, then issues two cycles after its wakeup
        disp(1, 9, 0, 0, 1); tick();
        disp(2, 0, 1, 0, 1); tick();
        tick(); cmp("ooo_b_first", 32'(iss_dst_o), 2);
        wb(9); tick(); cmp("ooo_gap", 32'(iss_valid_o), 0);
        tick(); cmp("ooo_a_valid", 32'(iss_valid_o), 1);
        cmp("ooo_a_dst", 32'(iss_dst_o), 1);
        tick();

        // wakeup bypass on the dispatch cycle
        disp(3, 0, 1, 12, 0); wb(12); tick();
        tick(); cmp("bypass_dst", 32'(iss_dst_o), 3);
        cmp("bypass_valid", 32'(iss_valid_o), 1);
        tick();

        // duplicate source tag woken by one broadcast
        disp(4, 14, 0, 14, 0); tick();
        wb(14); tick(); cmp("dup_not_yet", 32'(iss_valid_o), 0);
        tick(); cmp("dup_dst", 32'(iss_dst_o), 4);
        tick();

        // output holds under backpressure while an older entry wakes
        iss_ready_i = 0;
        disp(10, 20, 0, 0, 1); tick();
        disp(11, 0, 1, 0, 1); tick();
        tick(); cmp("hold_dst_a", 32'(iss_dst_o), 11);
        wb(20); tick(); tick(); tick();
        cmp("hold_dst_b", 32'(iss_dst_o), 11);
        cmp("hold_payload", iss_payload_o, 32'hC0DE_000B);
        iss_ready_i = 1; tick();
        cmp("hold_release", 32'(iss_dst_o), 10);
        tick(); cmp("hold_drained", 32'(iss_valid_o), 0);

        // fill the queue under backpressure
        iss_ready_i = 0;
        for (int i = 0; i < 8; i++) begin
            disp(16 + i, 0, 1, 0, 1); tick();
        end
        cmp("fill8_count", 32'(count_o), 7);
        cmp("fill8_ready", 32'(disp_ready_o), 1);
        disp(24, 0, 1, 0, 1); tick();
        cmp("full_count", 32'(count_o), 8);
        cmp("full_ready", 32'(disp_ready_o), 0);
        iss_ready_i = 1; tick(); iss_ready_i = 0;
        cmp("unfull_count", 32'(count_o), 7);
        cmp("unfull_ready", 32'(disp_ready_o), 1);
        cmp("unfull_dst", 32'(iss_dst_o), 17);
        iss_ready_i = 1;
        repeat (10) tick();
        cmp("fill_drained", 32'(count_o), 0);

        // flush wins over a same-cycle dispatch
        iss_ready_i = 0;
        for (int i = 1; i <= 6; i++) begin
            disp(i, 0, 1, 0, 1); tick();
        end
        cmp("preflush_count", 32'(count_o), 5);
        flush_i = 1; disp(7, 0, 1, 0, 1);
        #1 cmp("flush_ready", 32'(disp_ready_o), 0);
        tick();
        cmp("flush_count", 32'(count_o), 0);
        cmp("flush_valid", 32'(iss_valid_o), 0);
        iss_ready_i = 1;
        tick(); tick();
        cmp("flush_dropped", 32'(iss_valid_o), 0);

        // reset mid-operation discards in-flight entries
        disp(8, 0, 1, 0, 1); tick();
        disp(9, 0, 1, 0, 1); tick();
        rst = 1; tick(); rst = 0;
        cmp("mrst_count", 32'(count_o), 0);
        cmp("mrst_valid", 32'(iss_valid_o), 0);
        tick(); tick();
        cmp("mrst_empty", 32'(iss_valid_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
